// File: rtl/syndrome_check_seq.sv
// syndrome_check_seq: sequential LDPC syndrome checker, s = H*cw^T over GF(2).
// The codeword streams in as P-bit beats. The accumulated syndrome and a pass/fail
// flag leave through a valid/ready output. Accumulation stops for one result slot
// per codeword.
//
// Optional feature: define SYN_FAILCNT_EN to add fail_count. This is a saturating
// 16-bit count of output handshakes that carry check_fail=1.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   H_t          H transposed; column i = H_t[(i+1)*M-1 : i*M]; stable per codeword
//   in_valid     beat valid
//   in_ready     beat accepted on in_valid & in_ready
//   in_data      beat bits; in_data[j] = cw[beat*P + j]
//   out_valid    result valid
//   out_ready    result consumed on out_valid & out_ready
//   syndrome     accumulated syndrome (M bits)
//   check_fail   |syndrome
//   fail_count   (SYN_FAILCNT_EN only) saturating failed-codeword count
module syndrome_check_seq #(
  parameter int unsigned N = 6,
  parameter int unsigned K = 3,
  parameter int unsigned P = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*(N-K)-1:0] H_t,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [P-1:0]       in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-K-1:0]     syndrome,
`ifdef SYN_FAILCNT_EN
  output logic               check_fail,
  output logic [15:0]        fail_count
`else
  output logic               check_fail
`endif
);

  localparam int unsigned M  = N - K;
  localparam int unsigned B  = N / P;
  localparam int unsigned CW = (B > 1) ? $clog2(B) : 1;

  typedef enum logic {ST_ACC = 1'b0, ST_OUT = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_accept;
  logic            w_handshake;
  logic            w_last_beat;
  logic [CW-1:0]   r_cnt;
  logic [M-1:0]    r_syn;
  logic            r_fail;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [M-1:0]    w_beat_xor;
  logic [M-1:0]    w_syn_next;

  // Contribution of the current beat: XOR of the H columns selected by set bits.
  always_comb begin
    w_beat_xor = '0;
    for (int b = 0; b < int'(B); b++) begin
      if (r_cnt == CW'(b)) begin
        for (int j = 0; j < int'(P); j++) begin
          if (in_data[j]) begin
            w_beat_xor = w_beat_xor ^ H_t[(b*int'(P)+j)*int'(M) +: M];
          end
        end
      end
    end
  end

  assign w_syn_next  = r_syn ^ w_beat_xor;
  assign w_last_beat = (r_cnt == CW'(B - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_handshake  = 1'b0;
    case (r_state)
      ST_ACC: begin
        w_accept = in_valid;
        if (in_valid && w_last_beat) begin
          w_state_next = ST_OUT;
        end
      end
      ST_OUT: begin
        w_handshake = out_ready;
        if (out_ready) begin
          w_state_next = ST_ACC;
        end
      end
      default: w_state_next = ST_ACC;
    endcase
  end

  // Handshake flags are registered copies of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_next == ST_ACC);
      r_out_valid <= (w_state_next == ST_OUT);
    end
  end

  // Syndrome accumulator and beat counter; cleared when the result is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_syn  <= '0;
      r_fail <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_syn  <= w_syn_next;
      r_fail <= |w_syn_next;
      r_cnt  <= w_last_beat ? '0 : CW'(r_cnt + CW'(1));
    end else if (w_handshake) begin
      r_syn  <= '0;
      r_fail <= 1'b0;
    end
  end

`ifdef SYN_FAILCNT_EN
  logic [15:0] r_fail_cnt;

  // Saturating count of failed codewords at the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_cnt <= '0;
    end else if (w_handshake && r_fail && (r_fail_cnt != 16'hFFFF)) begin
      r_fail_cnt <= r_fail_cnt + 16'd1;
    end
  end

  assign fail_count = r_fail_cnt;
`endif

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign syndrome   = r_syn;
  assign check_fail = r_fail;

endmodule
